// File: rtl/rv32i_wbarbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_wbarbiter
// Purpose  : Shares the register-file write port between the pipeline WB stage
//            and a queued long-latency unit, with starvation stall and busy mask.
// Revision : 1.0
// ============================================================================
module rv32i_wbarbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_wb_en,
    input  logic [4:0]               pipe_wb_reg,
    input  logic [31:0]              pipe_wb_data,
    input  logic                     llu_valid,
    output logic                     llu_ready,
    input  logic [4:0]               llu_reg,
    input  logic [31:0]              llu_data,
    input  logic                     issue_en,
    input  logic [4:0]               issue_reg,
    output logic [31:0]              busy_mask,
    output logic                     stall_out,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     df_wb_enable,
    output logic [4:0]               df_wb_reg,
    output logic [31:0]              df_wb_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_SW = $clog2(STARVE_MAX) + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT   = c_CW'(DEPTH);
    localparam logic [c_SW-1:0] c_STARVE_LAST = c_SW'(STARVE_MAX - 1);

    logic [4:0]      r_fifo_reg  [DEPTH];
    logic [31:0]     r_fifo_data [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_SW-1:0] r_starve;
    logic            r_stall;
    logic [31:0]     r_busy;
    logic            r_we;
    logic [4:0]      r_waddr;
    logic [31:0]     r_wdata;

    logic            w_fifo_ne;
    logic            w_pipe_req;
    logic            w_grant_fifo;
    logic            w_grant_pipe;
    logic            w_push;
    logic            w_starve_inc;
    logic            w_starve_hit;
    logic [4:0]      w_head_reg;
    logic [31:0]     w_head_data;
    logic [31:0]     w_busy_set;
    logic [31:0]     w_busy_clr;

    assign w_fifo_ne   = (r_count != '0);
    assign w_pipe_req  = pipe_wb_en && (pipe_wb_reg != 5'd0);
    assign llu_ready   = (r_count < c_DEPTH_CNT);
    // Results for x0 are consumed from the LLU but never occupy a slot.
    assign w_push      = llu_valid && llu_ready && (llu_reg != 5'd0);
    assign w_head_reg  = r_fifo_reg[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // A pending forced stall outranks the pipeline; otherwise the pipeline wins.
    always_comb begin
        w_grant_fifo = 1'b0;
        w_grant_pipe = 1'b0;
        if (r_stall && w_fifo_ne) begin
            w_grant_fifo = 1'b1;
        end else if (w_pipe_req) begin
            w_grant_pipe = 1'b1;
        end else if (w_fifo_ne) begin
            w_grant_fifo = 1'b1;
        end
    end

    assign w_starve_inc = w_grant_pipe && w_fifo_ne;
    assign w_starve_hit = w_starve_inc && (r_starve == c_STARVE_LAST);
    assign w_busy_set   = (issue_en && (issue_reg != 5'd0)) ? (32'd1 << issue_reg) : 32'd0;
    assign w_busy_clr   = w_grant_fifo ? (32'd1 << w_head_reg) : 32'd0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_reg[r_wr_ptr]  <= llu_reg;
            r_fifo_data[r_wr_ptr] <= llu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
            r_busy   <= 32'd0;
            r_we     <= 1'b0;
            r_waddr  <= 5'd0;
            r_wdata  <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_grant_fifo) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_grant_fifo})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_starve_hit) begin
                r_starve <= '0;
            end else if (w_starve_inc) begin
                r_starve <= r_starve + c_SW'(1);
            end else begin
                r_starve <= '0;
            end
            r_stall <= w_starve_hit;
            // Set wins over clear; x0 can never be marked busy.
            r_busy  <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
            r_we    <= w_grant_pipe || w_grant_fifo;
            if (w_grant_pipe) begin
                r_waddr <= pipe_wb_reg;
                r_wdata <= pipe_wb_data;
            end else if (w_grant_fifo) begin
                r_waddr <= w_head_reg;
                r_wdata <= w_head_data;
            end
        end
    end

    assign busy_mask    = r_busy;
    assign stall_out    = r_stall;
    assign rf_we        = r_we;
    assign rf_waddr     = r_waddr;
    assign rf_wdata     = r_wdata;
    assign df_wb_enable = r_we;
    assign df_wb_reg    = r_waddr;
    assign df_wb_data   = r_wdata;
    assign fifo_count   = r_count;

endmodule
`default_nettype wire
